decision_wait_n: RTL and testbench

- Clocked, parametrised N-way decision-wait element.
- Mutually exclusive channel events a[i] are each joined with a shared "fire" event. When both have arrived, output event z[i] is produced.
- Extends the two-channel element with:
  - N channels;
  - selectable 2-phase or 4-phase signalling;
  - a buffered fire-token count;
  - error flags for protocol violations.
- Sits between a request arbiter (upstream) and channel-select datapath control (downstream) in clocked wrappers of async pipelines.

---
 rtl/decision_wait_n.sv | 129 ++++++++++++
 tb/tb_decision_wait_n.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decision_wait_n.sv
// ==========================================================================
// decision_wait_n : N-way clocked decision-wait (channel x fire join), rev 1.0
// ==========================================================================
`default_nettype none

module decision_wait_n #(
  parameter int N          = 2,
  parameter int FIRE_DEPTH = 2,
  parameter int PHASE      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fire,
  input  logic [N-1:0]                    a,
  input  logic [N-1:0]                    z_ack,
  output logic [N-1:0]                    z,
  output logic [$clog2(FIRE_DEPTH+1)-1:0] fire_cnt,
  output logic                            busy,
  output logic                            err_ovf,
  output logic                            err_multi
);

  localparam int CW = $clog2(FIRE_DEPTH+1);
  localparam logic [CW-1:0] c_one  = CW'(1);
  localparam logic [CW-1:0] c_full = CW'(FIRE_DEPTH);
  localparam logic [N-1:0]  c_one_n = N'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  state_t       state;
  logic         fire_q;
  logic [N-1:0] a_q;
  logic [N-1:0] pend;
  logic [N-1:0] lat_mask;

  logic         fire_ev;
  logic [N-1:0] a_ev;
  logic         multi_ev;
  logic         path_free;
  logic         issue;
  logic [N-1:0] low_mask;
  logic [N-1:0] issue_mask;
  logic         ack_k;

  // 2-phase: any edge is an event; 4-phase: only the rising edge counts.
  assign fire_ev = (PHASE == 2) ? (fire ^ fire_q) : (fire & ~fire_q);
  assign a_ev    = (PHASE == 2) ? (a ^ a_q)       : (a & ~a_q);

  // Two simultaneous events, or one event while a different channel waits.
  assign multi_ev = ((a_ev & (a_ev - c_one_n)) != '0) ||
                    ((a_ev != '0) && ((pend & ~a_ev) != '0));

  assign path_free  = (PHASE == 2) || (state == S_IDLE);
  assign issue      = (fire_cnt != '0) && (pend != '0) && path_free;
  assign low_mask   = pend & (~pend + c_one_n);
  assign issue_mask = issue ? low_mask : '0;
  assign ack_k      = (z_ack & lat_mask) != '0;

  assign busy = (pend != '0) || (fire_cnt != '0) ||
                ((PHASE == 4) && ((state != S_IDLE) || (z != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fire_q    <= 1'b0;
      a_q       <= '0;
      pend      <= '0;
      lat_mask  <= '0;
      z         <= '0;
      fire_cnt  <= '0;
      err_ovf   <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      fire_q <= fire;
      a_q    <= a;
      pend   <= (pend & ~issue_mask) | a_ev;

      if (multi_ev) begin
        err_multi <= 1'b1;
      end

      // A fire arriving together with an issue leaves the count unchanged.
      case ({fire_ev, issue})
        2'b10: begin
          if (fire_cnt == c_full) begin
            err_ovf <= 1'b1;
          end else begin
            fire_cnt <= fire_cnt + c_one;
          end
        end
        2'b01:   fire_cnt <= fire_cnt - c_one;
        default: ;
      endcase

      if (PHASE == 4) begin
        case (state)
          S_IDLE: begin
            if (issue) begin
              z        <= z | issue_mask;
              lat_mask <= issue_mask;
              state    <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (ack_k) begin
              z     <= z & ~lat_mask;
              state <= S_WAIT_REL;
            end
          end
          S_WAIT_REL: begin
            if (!ack_k) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (issue) begin
        z <= z ^ issue_mask;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decision_wait_n.sv
// ==========================================================================
// tb_decision_wait_n : directed self-checking bench for decision_wait_n, rev 1.0
// ==========================================================================
`default_nettype none

module tb_decision_wait_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: N=2, 2-phase
  logic       fire_a = 1'b0;
  logic [1:0] a_a = '0, zack_a = '0, z_a;
  logic [1:0] cnt_a;
  logic       busy_a, ovf_a, multi_a;

  // Instance B: N=4, 2-phase
  logic       fire_b = 1'b0;
  logic [3:0] a_b = '0, zack_b = '0, z_b;
  logic [1:0] cnt_b;
  logic       busy_b, ovf_b, multi_b;

  // Instance C: N=2, 4-phase
  logic       fire_c = 1'b0;
  logic [1:0] a_c = '0, zack_c = '0, z_c;
  logic [1:0] cnt_c;
  logic       busy_c, ovf_c, multi_c;

  decision_wait_n #(.N(2), .FIRE_DEPTH(2), .PHASE(2)) dut_a (
    .clk(clk), .rst(rst), .fire(fire_a), .a(a_a), .z_ack(zack_a), .z(z_a),
    .fire_cnt(cnt_a), .busy(busy_a), .err_ovf(ovf_a), .err_multi(multi_a));

  decision_wait_n #(.N(4), .FIRE_DEPTH(2), .PHASE(2)) dut_b (
    .clk(clk), .rst(rst), .fire(fire_b), .a(a_b), .z_ack(zack_b), .z(z_b),
    .fire_cnt(cnt_b), .busy(busy_b), .err_ovf(ovf_b), .err_multi(multi_b));

  decision_wait_n #(.N(2), .FIRE_DEPTH(2), .PHASE(4)) dut_c (
    .clk(clk), .rst(rst), .fire(fire_c), .a(a_c), .z_ack(zack_c), .z(z_c),
    .fire_cnt(cnt_c), .busy(busy_c), .err_ovf(ovf_c), .err_multi(multi_c));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_z_a",     32'(z_a), 32'h0);
    check("rst_cnt_a",   32'(cnt_a), 32'h0);
    check("rst_busy_a",  32'(busy_a), 32'h0);
    check("rst_ovf_a",   32'(ovf_a), 32'h0);
    check("rst_multi_b", 32'(multi_b), 32'h0);
    check("rst_z_c",     32'(z_c), 32'h0);
    rst = 1'b0;
    tick();

    // A: toggle a[1], fire two cycles later
    a_a = 2'b10;
    tick();
    check("a1_pend_busy", 32'(busy_a), 32'h1);
    check("a1_no_z",      32'(z_a), 32'h0);
    tick();
    tick();
    fire_a = 1'b1;
    tick();
    check("a1_cnt_up", 32'(cnt_a), 32'h1);
    check("a1_z_wait", 32'(z_a), 32'h0);
    tick();
    check("a1_z_issue", 32'(z_a), 32'h2);
    check("a1_cnt_dn",  32'(cnt_a), 32'h0);
    check("a1_idle",    32'(busy_a), 32'h0);
    tick();
    check("a1_z_once",  32'(z_a), 32'h2);

    // A: three fire toggles with depth 2, then a[0]
    fire_a = 1'b0; tick();
    fire_a = 1'b1; tick();
    check("ovf_cnt_full", 32'(cnt_a), 32'h2);
    check("ovf_not_yet",  32'(ovf_a), 32'h0);
    fire_a = 1'b0; tick();
    check("ovf_cnt_sat",  32'(cnt_a), 32'h2);
    check("ovf_flag",     32'(ovf_a), 32'h1);
    check("ovf_z_quiet",  32'(z_a), 32'h2);
    a_a = 2'b11;
    tick();
    tick();
    check("ovf_z0",     32'(z_a), 32'h3);
    check("ovf_cnt1",   32'(cnt_a), 32'h1);
    check("ovf_nomult", 32'(multi_a), 32'h0);

    // B: two tokens, simultaneous a[2] and a[3]
    fire_b = 1'b1; tick();
    fire_b = 1'b0; tick();
    check("b_cnt2", 32'(cnt_b), 32'h2);
    a_b = 4'b1100;
    tick();
    check("b_multi",  32'(multi_b), 32'h1);
    check("b_z_none", 32'(z_b), 32'h0);
    tick();
    check("b_z2",   32'(z_b), 32'h4);
    check("b_cnt1", 32'(cnt_b), 32'h1);
    tick();
    check("b_z3",   32'(z_b), 32'hC);
    check("b_cnt0", 32'(cnt_b), 32'h0);
    check("b_idle", 32'(busy_b), 32'h0);

    // B: fire+a captured together, then fire coinciding with an issue
    fire_b = 1'b1; a_b = 4'b1101;
    tick();
    check("b_both_cnt", 32'(cnt_b), 32'h1);
    check("b_both_z",   32'(z_b), 32'hC);
    fire_b = 1'b0;
    tick();
    check("b_net0_z",    32'(z_b), 32'hD);
    check("b_net0_cnt",  32'(cnt_b), 32'h1);
    check("b_net0_busy", 32'(busy_b), 32'h1);

    // C: 4-phase handshake
    fire_c = 1'b1; a_c = 2'b10;
    tick();
    check("c_z_wait", 32'(z_c), 32'h0);
    tick();
    check("c_z1_hi",  32'(z_c), 32'h2);
    check("c_busy",   32'(busy_c), 32'h1);
    fire_c = 1'b0; zack_c = 2'b01;
    tick();
    check("c_wrong_ack", 32'(z_c), 32'h2);
    zack_c = 2'b00;
    tick();
    check("c_still_hi",  32'(z_c), 32'h2);
    zack_c = 2'b10;
    tick();
    check("c_z1_lo",   32'(z_c), 32'h0);
    check("c_rel_busy", 32'(busy_c), 32'h1);
    fire_c = 1'b1; a_c = 2'b11;
    tick();
    check("c_hold_z",  32'(z_c), 32'h0);
    check("c_hold_cnt", 32'(cnt_c), 32'h1);
    tick();
    check("c_hold_z2", 32'(z_c), 32'h0);
    zack_c = 2'b00;
    tick();
    check("c_rel_z",   32'(z_c), 32'h0);
    tick();
    check("c_z0_hi",   32'(z_c), 32'h1);
    check("c_cnt0",    32'(cnt_c), 32'h0);
    check("c_nomulti", 32'(multi_c), 32'h0);

    // C: build pend and a token while in WAIT_ACK, then async reset
    fire_c = 1'b0; a_c = 2'b00;
    tick();
    fire_c = 1'b1; a_c = 2'b10;
    tick();
    check("c_pre_cnt", 32'(cnt_c), 32'h1);
    check("c_pre_z",   32'(z_c), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_z_c",     32'(z_c), 32'h0);
    check("ar_cnt_c",   32'(cnt_c), 32'h0);
    check("ar_busy_c",  32'(busy_c), 32'h0);
    check("ar_ovf_a",   32'(ovf_a), 32'h0);
    check("ar_multi_b", 32'(multi_b), 32'h0);
    check("ar_z_b",     32'(z_b), 32'h0);
    fire_a = 1'b0; a_a = '0;
    fire_b = 1'b0; a_b = '0;
    fire_c = 1'b0; a_c = '0; zack_c = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_z_c",    32'(z_c), 32'h0);
    check("post_busy_c", 32'(busy_c), 32'h0);
    check("post_z_a",    32'(z_a), 32'h0);
    fire_c = 1'b1; a_c = 2'b01;
    tick();
    tick();
    check("post_z0", 32'(z_c), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
